alu_div_share_ctrl: RTL and testbench
=====================================

Name: alu_div_share_ctrl

Overview:
Controller that time-shares one iterative integer divider among NUM_REQS ALU blocks.
- Arbitrates block requests round-robin and sequences the divider.
- Resolves RISC-V divide special cases without occupying the divider.
- Routes each result back to the requesting block with its tag.
- Sits between the per-block muldiv front-ends and a single shared divider core.

Parameters:
NUM_REQS, 4, number of requesting ALU blocks (1..16)
DATAW, 32, operand/result width (XLEN)
TAGW, 8, opaque request tag width returned with result

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
req_valid  in  NUM_REQS  per-block request valid
req_ready  out  NUM_REQS  per-block request accept
req_dividend  in  NUM_REQS*DATAW  dividend, block i at [i*DATAW +: DATAW]
req_divisor  in  NUM_REQS*DATAW  divisor, same packing
req_signed  in  NUM_REQS  1 = DIV/REM, 0 = DIVU/REMU
req_is_rem  in  NUM_REQS  1 = return remainder, 0 = quotient
req_tag  in  NUM_REQS*TAGW  tag, returned unchanged
div_start  out  1  one-cycle start pulse to divider
div_dividend  out  DATAW  operand to divider, valid while div_start
div_divisor  out  DATAW  operand to divider
div_signed  out  1  signedness to divider
div_done  in  1  divider result-valid pulse
div_quotient  in  DATAW  divider quotient, sampled on div_done
div_remainder  in  DATAW  divider remainder, sampled on div_done
rsp_valid  out  NUM_REQS  one-hot response valid to owning block
rsp_ready  in  NUM_REQS  per-block response accept
rsp_data  out  DATAW  result, shared bus qualified by rsp_valid
rsp_tag  out  TAGW  tag of the request being returned
busy  out  1  controller not in IDLE
perf_grants  out  32  count of accepted requests, wraps at 2^32

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- Reset (reset low, async): state IDLE, rr pointer 0, owner 0, all outputs 0 (req_ready, div_start, rsp_valid, busy, perf_grants, data buses).
- IDLE: grant the first valid requester at or after the rr pointer (modulo NUM_REQS).
  - req_ready is one-hot to the granted index, combinational in the same cycle; zero when no request is valid.
  - On accept: latch operands, signedness, rem flag and tag; owner <= grant; rr pointer <= grant+1 (wraps to 0); perf_grants += 1.
  - Special case → RESP; otherwise → ISSUE.
- Special cases, checked on the accepted operands:
  - divisor==0: quotient = all-ones; remainder = dividend.
  - signed, dividend==MIN (1 followed by DATAW-1 zeros), divisor==all-ones: quotient = MIN; remainder = 0.
- ISSUE: div_start=1 for exactly one cycle with latched operands → WAIT.
- WAIT: hold until div_done; latch quotient or remainder per rem flag → RESP.
  - div_done in any state other than WAIT is ignored.
- RESP: rsp_valid[owner]=1; rsp_data and rsp_tag stable until rsp_ready[owner]; on handshake → IDLE.
  - rsp_ready of non-owners is ignored.
- busy = (state != IDLE). req_ready is 0 in every state except IDLE, so there is no acceptance during RESP.
- Latency, accept at cycle T, divider done at D:
  - normal path: div_start T+1, rsp_valid from D+1.
  - special-case path: rsp_valid from T+1.
  - back-to-back: next accept no earlier than the cycle after the response handshake.
- Fairness: with all NUM_REQS requesting continuously, each block is served once per NUM_REQS grants.
- Reset asserted mid-operation: abandon the transaction, drop rsp_valid; a late div_done after reset release is ignored (state IDLE).

Decomposition:
- Shared package: state enum (IDLE/ISSUE/WAIT/RESP, 2 bits); helper function computing MIN/all-ones constants from DATAW.
- Sub-module alu_div_special (combinational):
  - inputs: dividend, divisor, signed.
  - outputs: is_special, special_quotient, special_remainder.
- Round-robin grant stays inline.

Test Plan:
- Single request, block 2: DIVU 100/7, tag 0x5A, divider model done after 33 cycles → div_start once; rsp_valid=4'b0100, rsp_data=14, rsp_tag=0x5A at done+1.
- REM signed -7/2 on block 0 → rsp_data=0xFFFFFFFF (-1); same with req_is_rem=0 → 0xFFFFFFFD (-3).
- Divisor 0, dividend 0x1234 on block 1: DIVU → rsp_data=0xFFFFFFFF at T+1, no div_start; REMU → 0x1234.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, no div_start.
- All 4 blocks valid continuously, rsp_ready always 1 → grant order 0,1,2,3,0,…; perf_grants=8 after 8 responses; req_ready never multi-hot.
- rsp_ready held low 10 cycles in RESP → rsp_data/rsp_tag stable, no new accept; pull reset low during WAIT → all outputs 0 asynchronously, then a subsequent div_done produces no rsp_valid.

Source files
------------

// File: rtl/alu_div_share_ctrl_pkg.sv
// Shared types and constant helpers for the shared-divider controller.
// Holds the FSM state encoding and the MIN / all-ones operand patterns.
package alu_div_share_ctrl_pkg;

    localparam int MAX_DATAW = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Most negative two's-complement value of width w, zero-extended to MAX_DATAW.
    function automatic logic [MAX_DATAW-1:0] min_const(input int w);
        return {{(MAX_DATAW-1){1'b0}}, 1'b1} << (w - 1);
    endfunction

    function automatic logic [MAX_DATAW-1:0] ones_const(input int w);
        return {MAX_DATAW{1'b1}} >> (MAX_DATAW - w);
    endfunction

endpackage

// File: rtl/alu_div_share_ctrl_if.sv
// Request/response, divider and status bus of the shared-divider controller.
// The slave modport is the controller's view; master is the surrounding system.
interface alu_div_share_ctrl_if #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 32,
    parameter int TAGW     = 8
);
    logic [NUM_REQS-1:0]       req_valid;
    logic [NUM_REQS-1:0]       req_ready;
    logic [NUM_REQS*DATAW-1:0] req_dividend;
    logic [NUM_REQS*DATAW-1:0] req_divisor;
    logic [NUM_REQS-1:0]       req_signed;
    logic [NUM_REQS-1:0]       req_is_rem;
    logic [NUM_REQS*TAGW-1:0]  req_tag;

    logic                      div_start;
    logic [DATAW-1:0]          div_dividend;
    logic [DATAW-1:0]          div_divisor;
    logic                      div_signed;
    logic                      div_done;
    logic [DATAW-1:0]          div_quotient;
    logic [DATAW-1:0]          div_remainder;

    logic [NUM_REQS-1:0]       rsp_valid;
    logic [NUM_REQS-1:0]       rsp_ready;
    logic [DATAW-1:0]          rsp_data;
    logic [TAGW-1:0]           rsp_tag;

    logic                      busy;
    logic [31:0]               perf_grants;

    modport slave (
        input  req_valid, req_dividend, req_divisor, req_signed, req_is_rem, req_tag,
        output req_ready,
        output div_start, div_dividend, div_divisor, div_signed,
        input  div_done, div_quotient, div_remainder,
        output rsp_valid, rsp_data, rsp_tag,
        input  rsp_ready,
        output busy, perf_grants
    );

    modport master (
        output req_valid, req_dividend, req_divisor, req_signed, req_is_rem, req_tag,
        input  req_ready,
        input  div_start, div_dividend, div_divisor, div_signed,
        output div_done, div_quotient, div_remainder,
        input  rsp_valid, rsp_data, rsp_tag,
        output rsp_ready,
        input  busy, perf_grants
    );
endinterface

// File: rtl/alu_div_share_ctrl_special.sv
// Detects RISC-V divide cases whose result is fixed by the ISA (divide by zero,
// signed overflow) so they can be answered without the iterative divider.
module alu_div_special
    import alu_div_share_ctrl_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  logic [DATAW-1:0] dividend,
    input  logic [DATAW-1:0] divisor,
    input  logic             is_signed,
    output logic             is_special,
    output logic [DATAW-1:0] special_quotient,
    output logic [DATAW-1:0] special_remainder
);
    localparam logic [DATAW-1:0] MIN_V  = DATAW'(min_const(DATAW));
    localparam logic [DATAW-1:0] ONES_V = DATAW'(ones_const(DATAW));

    always_comb begin
        is_special        = 1'b0;
        special_quotient  = ONES_V;
        special_remainder = dividend;
        if (divisor == '0) begin
            is_special = 1'b1;
        end else if (is_signed && (dividend == MIN_V) && (divisor == ONES_V)) begin
            is_special        = 1'b1;
            special_quotient  = MIN_V;
            special_remainder = '0;
        end
    end
endmodule

// File: rtl/alu_div_share_ctrl.sv
// Time-shares one iterative divider among NUM_REQS ALU blocks: round-robin
// grant, special-case bypass, divider sequencing and tagged response routing.
module alu_div_share_ctrl
    import alu_div_share_ctrl_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 32,
    parameter int TAGW     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_div_share_ctrl_if.slave  bus
);
    localparam int PTRW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    state_e               state, state_nxt;
    logic [PTRW-1:0]      rr_ptr, owner, grant_idx;
    logic                 grant_found, accept, owner_ready;
    logic [NUM_REQS-1:0]  grant_oh, owner_oh;

    logic [DATAW-1:0]     sel_dividend, sel_divisor;
    logic                 sel_signed, sel_rem;
    logic [TAGW-1:0]      sel_tag;

    logic [DATAW-1:0]     op_dividend, op_divisor, result;
    logic                 op_signed, op_rem;
    logic [TAGW-1:0]      op_tag;
    logic [31:0]          perf_q;

    logic                 is_special;
    logic [DATAW-1:0]     spec_q, spec_r;

    // First valid requester at or after rr_ptr, else first from index 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!grant_found && bus.req_valid[i] && (PTRW'(i) >= rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = PTRW'(i);
            end
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!grant_found && bus.req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = PTRW'(i);
            end
        end
    end

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        sel_signed   = 1'b0;
        sel_rem      = 1'b0;
        sel_tag      = '0;
        grant_oh     = '0;
        owner_oh     = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            grant_oh[i] = (PTRW'(i) == grant_idx);
            owner_oh[i] = (PTRW'(i) == owner);
            if (PTRW'(i) == grant_idx) begin
                sel_dividend = bus.req_dividend[i*DATAW +: DATAW];
                sel_divisor  = bus.req_divisor[i*DATAW +: DATAW];
                sel_signed   = bus.req_signed[i];
                sel_rem      = bus.req_is_rem[i];
                sel_tag      = bus.req_tag[i*TAGW +: TAGW];
            end
        end
    end

    alu_div_special #(.DATAW(DATAW)) u_special (
        .dividend          (sel_dividend),
        .divisor           (sel_divisor),
        .is_signed         (sel_signed),
        .is_special        (is_special),
        .special_quotient  (spec_q),
        .special_remainder (spec_r)
    );

    // Gated by reset so req_ready stays low while the controller is held in reset.
    assign accept      = reset && (state == ST_IDLE) && grant_found;
    assign owner_ready = |(bus.rsp_ready & owner_oh);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = is_special ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.div_done) state_nxt = ST_RESP;
            ST_RESP:  if (owner_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            owner       <= '0;
            op_dividend <= '0;
            op_divisor  <= '0;
            op_signed   <= 1'b0;
            op_rem      <= 1'b0;
            op_tag      <= '0;
            result      <= '0;
            perf_q      <= '0;
        end else begin
            if (accept) begin
                op_dividend <= sel_dividend;
                op_divisor  <= sel_divisor;
                op_signed   <= sel_signed;
                op_rem      <= sel_rem;
                op_tag      <= sel_tag;
                owner       <= grant_idx;
                rr_ptr      <= (grant_idx == PTRW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
                perf_q      <= perf_q + 32'd1;
                if (is_special) result <= sel_rem ? spec_r : spec_q;
            end
            if ((state == ST_WAIT) && bus.div_done) begin
                result <= op_rem ? bus.div_remainder : bus.div_quotient;
            end
        end
    end

    assign bus.req_ready    = accept ? grant_oh : '0;
    assign bus.div_start    = (state == ST_ISSUE);
    assign bus.div_dividend = op_dividend;
    assign bus.div_divisor  = op_divisor;
    assign bus.div_signed   = op_signed;
    assign bus.rsp_valid    = (state == ST_RESP) ? owner_oh : '0;
    assign bus.rsp_data     = result;
    assign bus.rsp_tag      = op_tag;
    assign bus.busy         = (state != ST_IDLE);
    assign bus.perf_grants  = perf_q;
endmodule

// File: tb/tb_alu_div_share_ctrl.sv
// Directed bench for alu_div_share_ctrl with a behavioural iterative divider
// of programmable latency on the divider side.
module tb_alu_div_share_ctrl;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int TW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    alu_div_share_ctrl_if #(.NUM_REQS(NR), .DATAW(DW), .TAGW(TW)) bus ();

    alu_div_share_ctrl #(.NUM_REQS(NR), .DATAW(DW), .TAGW(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int exp_grants = 0;
    int div_lat = 33;

    // Divider model: captures operands on div_start, pulses div_done div_lat cycles later.
    logic        mdl_busy = 1'b0;
    logic        mdl_done = 1'b0;
    int          mdl_cnt = 0;
    logic        mdl_s = 1'b0;
    logic [31:0] mdl_a = '0, mdl_b = '0, mdl_q = '0, mdl_r = '0;

    assign bus.div_done      = mdl_done;
    assign bus.div_quotient  = mdl_q;
    assign bus.div_remainder = mdl_r;

    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (mdl_busy) begin
            if (mdl_cnt <= 1) begin
                mdl_done <= 1'b1;
                mdl_busy <= 1'b0;
                if (mdl_s) begin
                    mdl_q <= $signed(mdl_a) / $signed(mdl_b);
                    mdl_r <= $signed(mdl_a) % $signed(mdl_b);
                end else begin
                    mdl_q <= mdl_a / mdl_b;
                    mdl_r <= mdl_a % mdl_b;
                end
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end else if (bus.div_start) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= div_lat;
            mdl_a    <= bus.div_dividend;
            mdl_b    <= bus.div_divisor;
            mdl_s    <= bus.div_signed;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input logic rem, input logic [7:0] tag);
        bus.req_dividend[idx*DW +: DW] = a;
        bus.req_divisor[idx*DW +: DW]  = b;
        bus.req_signed[idx]            = s;
        bus.req_is_rem[idx]            = rem;
        bus.req_tag[idx*TW +: TW]      = tag;
        bus.req_valid[idx]             = 1'b1;
    endtask

    // Issues one request and follows it to its response; cycle numbers count from accept+1.
    task automatic run_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic rem, input logic [7:0] tag,
                          output logic [3:0] rdy, output logic [3:0] vec,
                          output logic [31:0] data, output logic [7:0] tg,
                          output int starts, output int start_cyc,
                          output int done_cyc, output int rsp_cyc);
        vec = '0; data = '0; tg = '0;
        starts = 0; start_cyc = -1; done_cyc = -1; rsp_cyc = -1;
        @(negedge clk);
        drive_req(idx, a, b, s, rem, tag);
        #1 rdy = bus.req_ready;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[idx] = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (bus.rsp_valid != '0) begin
                rsp_cyc = c;
                vec     = bus.rsp_valid;
                data    = bus.rsp_data;
                tg      = bus.rsp_tag;
                break;
            end
            if (bus.div_start) begin
                starts++;
                if (start_cyc < 0) start_cyc = c;
            end
            if (bus.div_done) done_cyc = c;
            @(negedge clk);
        end
        @(negedge clk);
        exp_grants++;
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.rsp_ready = '1;
        repeat (3) @(negedge clk);
        vectors++; if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset req_ready: got %b want 0000", bus.req_ready); end
        vectors++; if ({bus.busy, bus.div_start, bus.rsp_valid} !== 6'b0) begin miscompares++; $display("FAIL reset ctrl: busy=%b start=%b rsp_valid=%b want 0", bus.busy, bus.div_start, bus.rsp_valid); end
        vectors++; if (bus.perf_grants !== 32'd0) begin miscompares++; $display("FAIL reset perf_grants: got %0d want 0", bus.perf_grants); end
        vectors++; if ({bus.rsp_data, bus.rsp_tag, bus.div_dividend, bus.div_divisor} !== '0) begin miscompares++; $display("FAIL reset data buses: rsp_data=%h rsp_tag=%h div_dividend=%h want 0", bus.rsp_data, bus.rsp_tag, bus.div_dividend); end
        bus.req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle no request: req_ready=%b busy=%b want 0000/0", bus.req_ready, bus.busy); end
    endtask

    task automatic test_single_divu();
        logic [3:0] rdy, vec; logic [31:0] data; logic [7:0] tg;
        int starts, sc, dc, rc;
        div_lat = 33;
        run_op(2, 32'd100, 32'd7, 1'b0, 1'b0, 8'h5A, rdy, vec, data, tg, starts, sc, dc, rc);
        vectors++; if (rdy !== 4'b0100) begin miscompares++; $display("FAIL divu req_ready: got %b want 0100", rdy); end
        vectors++; if (starts !== 1 || sc !== 1) begin miscompares++; $display("FAIL divu div_start: count %0d at cycle %0d want 1 at 1", starts, sc); end
        vectors++; if (dc < 30 || rc !== dc + 1) begin miscompares++; $display("FAIL divu latency: rsp at %0d done at %0d want rsp = done+1", rc, dc); end
        vectors++; if (vec !== 4'b0100) begin miscompares++; $display("FAIL divu rsp_valid: got %b want 0100", vec); end
        vectors++; if (data !== 32'd14) begin miscompares++; $display("FAIL divu rsp_data: got %h want 0000000e", data); end
        vectors++; if (tg !== 8'h5A) begin miscompares++; $display("FAIL divu rsp_tag: got %h want 5a", tg); end
        vectors++; if (bus.busy !== 1'b0 || bus.perf_grants !== 32'(exp_grants)) begin miscompares++; $display("FAIL divu after: busy=%b perf=%0d want 0/%0d", bus.busy, bus.perf_grants, exp_grants); end
    endtask

    task automatic test_signed();
        logic [3:0] rdy, vec; logic [31:0] data; logic [7:0] tg;
        int starts, sc, dc, rc;
        div_lat = 4;
        run_op(0, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 8'h11, rdy, vec, data, tg, starts, sc, dc, rc);
        vectors++; if (vec !== 4'b0001 || data !== 32'hFFFFFFFF || tg !== 8'h11) begin miscompares++; $display("FAIL rem -7/2: valid=%b data=%h tag=%h want 0001/ffffffff/11", vec, data, tg); end
        vectors++; if (starts !== 1 || rc !== dc + 1) begin miscompares++; $display("FAIL rem -7/2 path: starts=%0d rsp=%0d done=%0d want 1, done+1", starts, rc, dc); end
        run_op(0, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 8'h12, rdy, vec, data, tg, starts, sc, dc, rc);
        vectors++; if (data !== 32'hFFFFFFFD || tg !== 8'h12) begin miscompares++; $display("FAIL div -7/2: data=%h tag=%h want fffffffd/12", data, tg); end
    endtask

    task automatic test_div_zero();
        logic [3:0] rdy, vec; logic [31:0] data; logic [7:0] tg;
        int starts, sc, dc, rc;
        run_op(1, 32'h1234, 32'd0, 1'b0, 1'b0, 8'h22, rdy, vec, data, tg, starts, sc, dc, rc);
        vectors++; if (data !== 32'hFFFFFFFF || vec !== 4'b0010) begin miscompares++; $display("FAIL divu by 0: data=%h valid=%b want ffffffff/0010", data, vec); end
        vectors++; if (rc !== 1 || starts !== 0) begin miscompares++; $display("FAIL divu by 0 path: rsp at %0d starts=%0d want 1/0", rc, starts); end
        run_op(1, 32'h1234, 32'd0, 1'b0, 1'b1, 8'h23, rdy, vec, data, tg, starts, sc, dc, rc);
        vectors++; if (data !== 32'h1234 || rc !== 1 || starts !== 0 || tg !== 8'h23) begin miscompares++; $display("FAIL remu by 0: data=%h rsp at %0d starts=%0d tag=%h want 1234/1/0/23", data, rc, starts, tg); end
    endtask

    task automatic test_overflow();
        logic [3:0] rdy, vec; logic [31:0] data; logic [7:0] tg;
        int starts, sc, dc, rc;
        run_op(3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 8'h31, rdy, vec, data, tg, starts, sc, dc, rc);
        vectors++; if (data !== 32'h80000000 || rc !== 1 || starts !== 0) begin miscompares++; $display("FAIL div overflow: data=%h rsp at %0d starts=%0d want 80000000/1/0", data, rc, starts); end
        run_op(3, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 8'h32, rdy, vec, data, tg, starts, sc, dc, rc);
        vectors++; if (data !== 32'h0 || rc !== 1 || starts !== 0) begin miscompares++; $display("FAIL rem overflow: data=%h rsp at %0d starts=%0d want 0/1/0", data, rc, starts); end
        run_op(3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 8'h33, rdy, vec, data, tg, starts, sc, dc, rc);
        vectors++; if (data !== 32'h0 || starts !== 1 || vec !== 4'b1000) begin miscompares++; $display("FAIL unsigned min/ones: data=%h starts=%0d valid=%b want 0/1/1000", data, starts, vec); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  order [8];
        logic [31:0] dgot  [8];
        logic [7:0]  tgot  [8];
        logic [31:0] exp_q [4];
        logic [3:0]  e;
        int nresp;
        logic multihot;
        exp_q[0] = 32'd100; exp_q[1] = 32'd50; exp_q[2] = 32'd34; exp_q[3] = 32'd25;
        for (int k = 0; k < 8; k++) begin order[k] = '0; dgot[k] = '0; tgot[k] = '0; end
        div_lat = 3;
        nresp = 0;
        multihot = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NR; i++) drive_req(i, 32'(100 + i), 32'(i + 1), 1'b0, 1'b0, 8'(8'hA0 + i));
        #1;
        for (int c = 0; c < 1000; c++) begin
            if (!$onehot0(bus.req_ready)) multihot = 1'b1;
            if (bus.rsp_valid != '0) begin
                order[nresp] = bus.rsp_valid;
                dgot[nresp]  = bus.rsp_data;
                tgot[nresp]  = bus.rsp_tag;
                nresp++;
                if (nresp == 8) begin
                    bus.req_valid = '0;
                    break;
                end
            end
            @(negedge clk);
        end
        @(negedge clk);
        exp_grants += 8;
        vectors++; if (nresp !== 8) begin miscompares++; $display("FAIL rr response count: got %0d want 8", nresp); end
        for (int k = 0; k < 8; k++) begin
            e = 4'b0001 << (k % 4);
            vectors++;
            if (order[k] !== e || dgot[k] !== exp_q[k % 4] || tgot[k] !== 8'(8'hA0 + k % 4)) begin
                miscompares++;
                $display("FAIL rr response %0d: valid=%b data=%0d tag=%h want %b/%0d/%h", k, order[k], dgot[k], tgot[k], e, exp_q[k % 4], 8'(8'hA0 + k % 4));
            end
        end
        vectors++; if (multihot !== 1'b0) begin miscompares++; $display("FAIL rr req_ready multi-hot: got %b want 0", multihot); end
        vectors++; if (bus.perf_grants !== 32'(exp_grants)) begin miscompares++; $display("FAIL rr perf_grants: got %0d want %0d", bus.perf_grants, exp_grants); end
    endtask

    task automatic test_resp_hold();
        @(negedge clk);
        bus.rsp_ready = 4'b1101;
        drive_req(1, 32'hBEEF, 32'd0, 1'b0, 1'b1, 8'h3C);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        drive_req(0, 32'd9, 32'd3, 1'b0, 1'b0, 8'h01);
        #1;
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 32'hBEEF || bus.rsp_tag !== 8'h3C || bus.req_ready !== 4'b0000) begin
                miscompares++;
                $display("FAIL hold cycle %0d: valid=%b data=%h tag=%h req_ready=%b want 0010/beef/3c/0000", c, bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.req_ready);
            end
            @(negedge clk);
        end
        bus.rsp_ready = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        #1;
        vectors++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL after hold: valid=%b busy=%b req_ready=%b want 0000/0/0001", bus.rsp_valid, bus.busy, bus.req_ready); end
        bus.req_valid = '0;
        exp_grants++;
        @(negedge clk);
        vectors++; if (bus.perf_grants !== 32'(exp_grants) || bus.busy !== 1'b0) begin miscompares++; $display("FAIL hold grants: perf=%0d busy=%b want %0d/0", bus.perf_grants, bus.busy, exp_grants); end
    endtask

    task automatic test_reset_mid();
        logic bad, seen;
        div_lat = 20;
        bad = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        drive_req(2, 32'd50, 32'd5, 1'b0, 1'b0, 8'h77);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (bus.busy !== 1'b1 || bus.rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL pre-reset wait: busy=%b valid=%b want 1/0000", bus.busy, bus.rsp_valid); end
        #2 reset = 1'b0;
        #1;
        vectors++; if ({bus.busy, bus.div_start, bus.rsp_valid, bus.req_ready} !== 10'b0) begin miscompares++; $display("FAIL async reset ctrl: busy=%b start=%b valid=%b ready=%b want 0", bus.busy, bus.div_start, bus.rsp_valid, bus.req_ready); end
        vectors++; if (bus.perf_grants !== 32'd0 || bus.div_dividend !== 32'd0 || bus.rsp_tag !== 8'd0) begin miscompares++; $display("FAIL async reset data: perf=%0d dividend=%h tag=%h want 0", bus.perf_grants, bus.div_dividend, bus.rsp_tag); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        exp_grants = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) bad = 1'b1;
            if (bus.div_done === 1'b1) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL late div_done: seen=%b want 1", seen); end
        vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL late div_done response: flagged=%b want 0", bad); end
    endtask

    initial begin
        bus.req_valid    = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.req_signed   = '0;
        bus.req_is_rem   = '0;
        bus.req_tag      = '0;
        bus.rsp_ready    = '1;
        test_reset();
        test_single_divu();
        test_signed();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_resp_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
